// File: rtl/fp_sum3_pkg.sv
// Shared types and constants for the three-operand FP adder result path.
package fp_sum3_pkg;

   localparam int unsigned def_sig_width = 23;
   localparam int unsigned def_exp_width = 8;
   localparam int unsigned def_id_width  = 8;
   localparam int unsigned status_w      = 8;
   localparam int unsigned def_z_w       = def_sig_width + def_exp_width + 1;

   // Bit positions within the IEEE status byte
   localparam int unsigned st_zero         = 0;
   localparam int unsigned st_inf          = 1;
   localparam int unsigned st_invalid      = 2;
   localparam int unsigned st_tiny         = 3;
   localparam int unsigned st_huge         = 4;
   localparam int unsigned st_inexact      = 5;
   localparam int unsigned st_hugeint      = 6;
   localparam int unsigned st_compspecific = 7;

   typedef struct packed {
      logic [def_z_w-1:0]      z;
      logic [status_w-1:0]     status;
      logic [def_id_width-1:0] id;
   } rb_entry_t;

endpackage

// File: rtl/fp_sum3_result_buf_if.sv
// Adder-side and consumer-side signals of the result buffer.
interface fp_sum3_result_buf_if
   import fp_sum3_pkg::*;
#(
   parameter int unsigned sig_width = def_sig_width,
   parameter int unsigned exp_width = def_exp_width,
   parameter int unsigned id_width  = def_id_width
) ();

   localparam int unsigned z_w = sig_width + exp_width + 1;

   logic                arrive;
   logic [id_width-1:0] arrive_id;
   logic [z_w-1:0]      z;
   logic [status_w-1:0] status;
   logic                accept_n;

   logic                out_valid;
   logic                out_ready;
   logic [z_w-1:0]      out_z;
   logic [status_w-1:0] out_status;
   logic [id_width-1:0] out_id;

   // master: adder plus consumer; slave: the result buffer
   modport master (
      output arrive, arrive_id, z, status, out_ready,
      input  accept_n, out_valid, out_z, out_status, out_id
   );

   modport slave (
      input  arrive, arrive_id, z, status, out_ready,
      output accept_n, out_valid, out_z, out_status, out_id
   );

endinterface

// File: rtl/fp_sum3_rb_fifo.sv
// In-order result storage with pointers, occupancy count and registered
// not_empty/full flags.
module fp_sum3_rb_fifo #(
   parameter int unsigned data_w = 48,
   parameter int unsigned depth  = 4,
   localparam int unsigned cnt_w = $clog2(depth + 1),
   localparam int unsigned ptr_w = $clog2(depth)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [data_w-1:0] wr_data,
   input  logic              rd_en,
   output logic [data_w-1:0] rd_data,
   output logic [cnt_w-1:0]  count,
   output logic              not_empty,
   output logic              full
);

   logic [data_w-1:0] mem [depth];
   logic [ptr_w-1:0]  wr_ptr;
   logic [ptr_w-1:0]  rd_ptr;
   logic [cnt_w-1:0]  count_nxt;

   always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en) begin
         count_nxt = count + cnt_w'(1);
      end else if (rd_en && !wr_en) begin
         count_nxt = count - cnt_w'(1);
      end
   end

   // Flags track count_nxt so they stay registered alongside count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         not_empty <= 1'b0;
         full      <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ptr_w'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
         end
         count     <= count_nxt;
         not_empty <= (count_nxt != '0);
         full      <= (count_nxt == cnt_w'(depth));
      end
   end

   // Storage carries no reset; contents are ignored while empty
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fp_sum3_result_buf.sv
// Captures adder results into an in-order buffer, applies backpressure when
// full, checks arrival ID sequence and accumulates sticky status flags.
module fp_sum3_result_buf
   import fp_sum3_pkg::*;
#(
   parameter int unsigned sig_width = def_sig_width,
   parameter int unsigned exp_width = def_exp_width,
   parameter int unsigned id_width  = def_id_width,
   parameter int unsigned depth     = 4,
   localparam int unsigned cnt_w    = $clog2(depth + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   fp_sum3_result_buf_if.slave  bus,
   input  logic                 clr_sticky,
   output logic [cnt_w-1:0]     count,
   output logic [status_w-1:0]  sticky_status,
   output logic                 seq_err
);

   localparam int unsigned z_w     = sig_width + exp_width + 1;
   localparam int unsigned entry_w = z_w + status_w + id_width;

   logic                cap;
   logic                pop;
   logic                full;
   logic                not_empty;
   logic [entry_w-1:0]  head;
   logic [id_width-1:0] exp_id;
   logic                mism;
   logic [status_w-1:0] sticky_nxt;
   logic                seq_err_nxt;

   // Backpressure depends only on registered occupancy
   assign cap = bus.arrive & ~full & ~rst;
   assign pop = not_empty & bus.out_ready;

   fp_sum3_rb_fifo #(
      .data_w (entry_w),
      .depth  (depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (cap),
      .wr_data   ({bus.z, bus.status, bus.arrive_id}),
      .rd_en     (pop),
      .rd_data   (head),
      .count     (count),
      .not_empty (not_empty),
      .full      (full)
   );

   assign bus.accept_n  = full;
   assign bus.out_valid = not_empty;
   assign {bus.out_z, bus.out_status, bus.out_id} = head;

   // A clear coinciding with a capture keeps only that capture's contribution
   always_comb begin
      mism        = cap & (bus.arrive_id != exp_id);
      sticky_nxt  = sticky_status | (cap ? bus.status : '0);
      seq_err_nxt = seq_err | mism;
      if (clr_sticky) begin
         sticky_nxt  = cap ? bus.status : '0;
         seq_err_nxt = mism;
      end
   end

   // Expected ID follows the last captured ID, resynchronising after a gap
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_id        <= '0;
         sticky_status <= '0;
         seq_err       <= 1'b0;
      end else begin
         if (cap) begin
            exp_id <= bus.arrive_id + id_width'(1);
         end
         sticky_status <= sticky_nxt;
         seq_err       <= seq_err_nxt;
      end
   end

endmodule

// File: tb/tb_fp_sum3_result_buf.sv
// Self-checking bench for fp_sum3_result_buf: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_fp_sum3_result_buf;
   import fp_sum3_pkg::*;

   localparam int unsigned depth = 4;
   localparam int unsigned cnt_w = $clog2(depth + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             clr_sticky;
   logic [cnt_w-1:0] count;
   logic [7:0]       sticky_status;
   logic             seq_err;

   always #5 clk = ~clk;

   fp_sum3_result_buf_if #(
      .sig_width (def_sig_width),
      .exp_width (def_exp_width),
      .id_width  (def_id_width)
   ) bus ();

   fp_sum3_result_buf #(
      .sig_width (def_sig_width),
      .exp_width (def_exp_width),
      .id_width  (def_id_width),
      .depth     (depth)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .clr_sticky    (clr_sticky),
      .count         (count),
      .sticky_status (sticky_status),
      .seq_err       (seq_err)
   );

   rb_entry_t  src_q[$];   // results the adder still has to deliver
   rb_entry_t  mdl_q[$];   // expected buffer contents, head first
   logic [7:0] popped[$];  // IDs the consumer took, as seen on the DUT
   logic [7:0] m_sticky   = 8'h00;
   logic       m_seq_err  = 1'b0;
   logic [7:0] m_exp_id   = 8'h00;
   int         n_tests    = 0;
   int         n_fail     = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic rb_entry_t mk(input logic [7:0] id, input logic [7:0] st);
      rb_entry_t e;
      e.z      = $urandom;
      e.status = st;
      e.id     = id;
      return e;
   endfunction

   // One clock: present the adder's pending result, check registered outputs
   // against the model, advance the model by the buffer's rules.
   task automatic step(input bit gap);
      bit        m_full;
      bit        cap;
      bit        mism;
      rb_entry_t e;
      m_full = (mdl_q.size() == depth);
      if (src_q.size() != 0 && (!gap || m_full)) begin
         e             = src_q[0];
         bus.arrive    = 1'b1;
         bus.arrive_id = e.id;
         bus.z         = e.z;
         bus.status    = e.status;
      end else begin
         bus.arrive    = 1'b0;
         bus.arrive_id = 8'($urandom);
         bus.z         = $urandom;
         bus.status    = 8'($urandom);
      end
      chk("out_valid", 64'(bus.out_valid), 64'(mdl_q.size() != 0));
      chk("accept_n", 64'(bus.accept_n), 64'(m_full));
      chk("count", 64'(count), 64'(mdl_q.size()));
      chk("sticky_status", 64'(sticky_status), 64'(m_sticky));
      chk("seq_err", 64'(seq_err), 64'(m_seq_err));
      if (mdl_q.size() != 0) begin
         chk("out_id", 64'(bus.out_id), 64'(mdl_q[0].id));
         chk("out_z", 64'(bus.out_z), 64'(mdl_q[0].z));
         chk("out_status", 64'(bus.out_status), 64'(mdl_q[0].status));
      end
      if (bus.out_valid && bus.out_ready && !rst) popped.push_back(bus.out_id);
      cap = bus.arrive && !m_full && !rst;
      if (rst) begin
         mdl_q.delete();
         m_sticky  = 8'h00;
         m_seq_err = 1'b0;
         m_exp_id  = 8'h00;
      end else begin
         mism = cap && (bus.arrive_id != m_exp_id);
         if (mdl_q.size() != 0 && bus.out_ready) void'(mdl_q.pop_front());
         if (cap) begin
            mdl_q.push_back(src_q[0]);
            m_exp_id = bus.arrive_id + 8'd1;
         end
         if (clr_sticky) begin
            m_sticky  = cap ? bus.status : 8'h00;
            m_seq_err = mism;
         end else begin
            if (cap) m_sticky = m_sticky | bus.status;
            m_seq_err = m_seq_err | mism;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (cap) void'(src_q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0);
      rst = 1'b0;
   endtask

   initial begin
      logic [cnt_w-1:0] peak;
      logic [7:0]       next_id;
      rst           = 1'b1;
      clr_sticky    = 1'b0;
      bus.arrive    = 1'b0;
      bus.arrive_id = 8'h00;
      bus.z         = '0;
      bus.status    = 8'h00;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_accept_n", 64'(bus.accept_n), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_sticky", 64'(sticky_status), 64'h00);
      chk("rst_seq_err", 64'(seq_err), 64'd0);
      rst = 1'b0;

      // Back-to-back pass-through, consumer always ready
      bus.out_ready = 1'b1;
      peak = '0;
      for (int i = 0; i < 3; i++) src_q.push_back(mk(8'(i), 8'h00));
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         chk("pass_out_id", 64'(bus.out_id), 64'(i));
         if (count > peak) peak = count;
      end
      step(1'b0);
      chk("pass_peak", 64'(peak), 64'd1);
      chk("pass_seq_err", 64'(seq_err), 64'd0);

      // Backpressure: fill, hold ID 4, single pop, then drain
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) src_q.push_back(mk(8'(i), 8'h00));
      repeat (5) step(1'b0);
      chk("bp_full_count", 64'(count), 64'd4);
      chk("bp_full_accept_n", 64'(bus.accept_n), 64'd1);
      step(1'b0);
      chk("bp_held_count", 64'(count), 64'd4);
      bus.out_ready = 1'b1;
      step(1'b0);
      bus.out_ready = 1'b0;
      chk("bp_pop_count", 64'(count), 64'd3);
      chk("bp_pop_accept_n", 64'(bus.accept_n), 64'd0);
      step(1'b0);
      chk("bp_refill_count", 64'(count), 64'd4);
      popped.delete();
      bus.out_ready = 1'b1;
      repeat (5) step(1'b0);
      chk("bp_drain_len", 64'(popped.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < popped.size()) chk("bp_drain_order", 64'(popped[k]), 64'(k + 1));
      end

      // Sticky status accumulation and clear-with-capture
      do_reset();
      bus.out_ready = 1'b1;
      src_q.push_back(mk(8'd0, 8'(1 << st_inexact)));
      src_q.push_back(mk(8'd1, 8'(1 << st_invalid)));
      step(1'b0);
      step(1'b0);
      chk("sticky_or", 64'(sticky_status), 64'h24);
      src_q.push_back(mk(8'd2, 8'(1 << st_zero)));
      clr_sticky = 1'b1;
      step(1'b0);
      clr_sticky = 1'b0;
      chk("sticky_clr_cap", 64'(sticky_status), 64'h01);
      step(1'b0);

      // Sequence error on a skipped ID
      do_reset();
      foreach (src_q[i]) ;
      src_q.push_back(mk(8'd0, 8'h00));
      src_q.push_back(mk(8'd1, 8'h00));
      src_q.push_back(mk(8'd3, 8'h00));
      src_q.push_back(mk(8'd4, 8'h00));
      step(1'b0);
      step(1'b0);
      chk("seq_ok", 64'(seq_err), 64'd0);
      step(1'b0);
      chk("seq_set", 64'(seq_err), 64'd1);
      step(1'b0);
      chk("seq_hold", 64'(seq_err), 64'd1);
      clr_sticky = 1'b1;
      step(1'b0);
      clr_sticky = 1'b0;
      chk("seq_clr", 64'(seq_err), 64'd0);

      // Reset while full with a result presented
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) src_q.push_back(mk(8'(i + 16), 8'h00));
      repeat (5) step(1'b0);
      chk("rf_full", 64'(count), 64'd4);
      rst = 1'b1;
      step(1'b0);
      rst = 1'b0;
      chk("rf_count", 64'(count), 64'd0);
      chk("rf_out_valid", 64'(bus.out_valid), 64'd0);
      step(1'b0);
      chk("rf_recapture_count", 64'(count), 64'd1);
      chk("rf_recapture_id", 64'(bus.out_id), 64'd20);
      bus.out_ready = 1'b1;
      repeat (2) step(1'b0);

      // Randomized traffic: mostly sequential IDs, gaps, stalls, clears
      do_reset();
      next_id = 8'h00;
      for (int c = 0; c < 600; c++) begin
         if (src_q.size() < 3 && $urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 15) == 0) next_id = next_id + 8'($urandom_range(1, 3));
            src_q.push_back(mk(next_id, 8'($urandom) & 8'($urandom) & 8'($urandom)));
            next_id = next_id + 8'd1;
         end
         bus.out_ready = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         clr_sticky    = ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 4) == 0);
      end
      clr_sticky    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (12) step(1'b0);
      chk("rand_drained", 64'(count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_sum3_result_buf.md
# fp_sum3_result_buf

Result-capture buffer that sits directly downstream of the pipelined three-operand floating-point adder. It consumes the adder's `arrive`, `arrive_id`, `z` and `status` outputs, drives the adder's `accept_n` backpressure input, and presents results in order to the consumer over a valid/ready handshake. It also checks ID sequence and accumulates sticky exception flags.

## Interface
Parameters:
- `sig_width`, 23, significand width of `z`.
- `exp_width`, 8, exponent width of `z`.
- `id_width`, 8, launch/arrive ID width.
- `depth`, 4, FIFO entries; power of 2, range 2..64.

Ports (`cnt_w` = clog2(depth+1)):
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `arrive`  in  1  adder result present.
- `arrive_id`  in  id_width  ID of the presented result.
- `z`  in  sig_width+exp_width+1  sum result.
- `status`  in  8  IEEE status flags of the presented result.
- `accept_n`  out  1  to the adder; 1 = hold the result, do not advance.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_z`  out  sig_width+exp_width+1  head result.
- `out_status`  out  8  head status.
- `out_id`  out  id_width  head ID.
- `count`  out  cnt_w  occupied entries.
- `sticky_status`  out  8  OR of the status of every captured result since the last clear.
- `clr_sticky`  in  1  clears `sticky_status` and `seq_err`.
- `seq_err`  out  1  sticky flag; a captured ID differed from the expected ID.

## Operation
- Capture: `cap = arrive & ~accept_n`. On `cap`, write {z, status, arrive_id} at `wr_ptr` and increment `wr_ptr` modulo depth. When `arrive` is high while `accept_n` is high, nothing is captured; the adder holds its output.
- Pop: `pop = out_valid & out_ready`. On `pop`, increment `rd_ptr` modulo depth.
- Count update:
  - `cap & ~pop`: +1.
  - `pop & ~cap`: −1.
  - Both or neither: unchanged.
- `accept_n = (count == depth)`. It is a function of registered count only; there is no combinational path from `out_ready` or `arrive`. When full with a pop in the same cycle, there is still no capture that cycle.
- `out_valid = (count != 0)`. `out_*` are the head entry read from registers; they hold stable while `out_valid & ~out_ready`.
- No bypass: a result captured into an empty buffer appears on `out_*` the next cycle.
- Sequence check: register `exp_id` resets to 0.
  - On `cap`, if `arrive_id != exp_id`, set `seq_err`.
  - On every `cap`, load `exp_id <= arrive_id + 1`, wrapping modulo 2^id_width. This resynchronises after an error.
- Sticky status:
  - On `cap`: `sticky_status <= sticky_status | status`.
  - On `clr_sticky` without `cap`: `sticky_status <= 0`, `seq_err <= 0`.
  - On `clr_sticky` with `cap` in the same cycle: `sticky_status <= status`, and `seq_err` takes only the current cycle's comparison.
- Reset values:
  - Pointers, count, `exp_id`, `sticky_status` and `seq_err` are 0.
  - `out_valid` = 0 and `accept_n` = 0.
  - FIFO storage is not reset; `out_z`/`out_status`/`out_id` are don't-care while `out_valid` = 0.
- Reset mid-operation flushes all entries. Any result the adder presents during the reset cycle is not captured (`cap` is gated by `~rst`). The adder is reset by the same `rst` domain.

## Timing
- Capture-to-`out_valid` latency: 1 cycle.
- Pop-to-next-head: next cycle.
- Throughput: 1 result per cycle in and out while 0 < count < depth.
- `accept_n` rises in the cycle after the capture that fills the buffer. It falls in the cycle after the first pop from full.
- Sustained full with `out_ready` = 1 throughout gives 1 result per 2 cycles. This is accepted; choose `depth` ≥ 2 for full rate.
- `count`, `sticky_status` and `seq_err` are registered outputs.

## Structure
- Shared package `fp_sum3_pkg`:
  - status bit index constants (zero, inf, invalid, tiny, huge, inexact, hugeint, compspecific);
  - a typedef for the FIFO entry struct {z, status, id}.
- One sub-module, `fp_sum3_rb_fifo`: storage plus pointers and count, with a `full` output.
- The top level holds the `accept_n` logic, the sequence checker and the sticky accumulators.

## Test plan
- Reset with `depth` = 4: `out_valid` = 0, `accept_n` = 0, `count` = 0, `sticky_status` = 0x00, `seq_err` = 0.
- IDs 0,1,2 arrive on consecutive cycles with `out_ready` = 1:
  - `out_id` = 0,1,2 on cycles 1,2,3 after each capture;
  - `count` peaks at 1;
  - `seq_err` stays 0.
- `out_ready` = 0 with 5 arrivals (IDs 0..4):
  - `count` reaches 4 and `accept_n` = 1;
  - ID 4 is held and not captured.
  - Raise `out_ready` for one cycle: ID 0 pops, ID 4 is captured the following cycle, and the final drain order is 1,2,3,4.
- Arrival with status 0x20, then with status 0x04: `sticky_status` = 0x24. Then `clr_sticky` together with an arrival of status 0x01: `sticky_status` = 0x01.
- IDs 0,1,3,4 arrive:
  - `seq_err` is set the cycle after ID 3 is captured;
  - it stays set through ID 4;
  - it clears on `clr_sticky`.
- `rst` asserted while full and while `arrive` = 1: the next cycle has `count` = 0 and `out_valid` = 0, and the presented result is not captured.
